ibex_ahb_arbiter: RTL and testbench

- Shares the single AHB-Lite master port of the SoC between the Ibex core's instruction-fetch and data-LSU request/grant/rvalid interfaces.
- Runs the AHB address and data phases as a true pipeline, so a new address phase can overlap the previous data phase.
- Converts byte enables into HSIZE and the low HADDR bits.
- Routes HRDATA and HRESP back to whichever requester owns the current data phase.

---
 rtl/ibex_ahb_pkg.sv | 27 ++
 rtl/ibex_ahb_arbiter_if.sv | 63 ++++++
 rtl/ibex_ahb_be_decode.sv | 35 +++
 rtl/ibex_ahb_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_ibex_ahb_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_ahb_pkg.sv
// ----------------------------------------------------------------------------
// ibex_ahb_pkg
// Shared constants and types for the Ibex-to-AHB-Lite arbiter slice:
//   - HTRANS encodings (only IDLE and NONSEQ are ever issued)
//   - HSIZE encodings for byte / halfword / word transfers
//   - HRESP encodings
//   - owner_e: which requester owns the AHB data phase in flight
// ----------------------------------------------------------------------------
package ibex_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

endpackage

// File: rtl/ibex_ahb_arbiter_if.sv
// ----------------------------------------------------------------------------
// ibex_ahb_arbiter_if
// Bundles the Ibex instruction-fetch and LSU request/grant/rvalid signals
// together with the AHB-Lite master port that the arbiter shares between them.
//   modport master : arbiter view (consumes requests and AHB responses,
//                    drives grants, responses and the AHB address/data phase)
//   modport slave  : environment view (core requesters plus AHB fabric)
// Fetch side : instr_req_i, instr_addr_i / instr_gnt_o, instr_rvalid_o,
//              instr_rdata_o, instr_err_o
// LSU side   : data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i /
//              data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
// AHB side   : HADDR, HTRANS, HSIZE, HWRITE, HPROT, HWDATA / HRDATA, HREADY,
//              HRESP
// ----------------------------------------------------------------------------
interface ibex_ahb_arbiter_if;
    import ibex_ahb_pkg::*;

    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;

    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output HADDR, HTRANS, HSIZE, HWRITE, HPROT, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  HADDR, HTRANS, HSIZE, HWRITE, HPROT, HWDATA,
        output HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/ibex_ahb_be_decode.sv
// ----------------------------------------------------------------------------
// ibex_ahb_be_decode
// Combinational mapping of LSU byte enables onto an AHB transfer size and the
// two low address bits.
//   be_i       in  4  byte enables
//   hsize_o    out 3  AHB HSIZE
//   addr_lsb_o out 2  HADDR[1:0]
// Byte and naturally aligned halfword patterns map to narrow transfers; any
// other pattern (including sparse or misaligned ones) is issued as a word.
// ----------------------------------------------------------------------------
module ibex_ahb_be_decode
    import ibex_ahb_pkg::*;
(
    input  logic [3:0] be_i,
    output logic [2:0] hsize_o,
    output logic [1:0] addr_lsb_o
);

    // Byte-enable pattern to (size, low address) lookup
    always_comb begin
        hsize_o    = HSIZE_WORD;
        addr_lsb_o = 2'b00;
        case (be_i)
            4'b0001: begin hsize_o = HSIZE_BYTE; addr_lsb_o = 2'b00; end
            4'b0010: begin hsize_o = HSIZE_BYTE; addr_lsb_o = 2'b01; end
            4'b0100: begin hsize_o = HSIZE_BYTE; addr_lsb_o = 2'b10; end
            4'b1000: begin hsize_o = HSIZE_BYTE; addr_lsb_o = 2'b11; end
            4'b0011: begin hsize_o = HSIZE_HALF; addr_lsb_o = 2'b00; end
            4'b1100: begin hsize_o = HSIZE_HALF; addr_lsb_o = 2'b10; end
            4'b1111: begin hsize_o = HSIZE_WORD; addr_lsb_o = 2'b00; end
            default: begin hsize_o = HSIZE_WORD; addr_lsb_o = 2'b00; end
        endcase
    end

endmodule

// File: rtl/ibex_ahb_arbiter.sv
// ----------------------------------------------------------------------------
// ibex_ahb_arbiter
// Shares one AHB-Lite master port between the Ibex instruction-fetch and LSU
// request/grant/rvalid interfaces. Address and data phases are pipelined: a
// new address phase may be granted in the same cycle the previous data phase
// completes, giving one transfer per cycle at zero wait states.
//
// Ports:
//   HCLK     in   system clock
//   HRESETn  in   asynchronous active-low reset
//   bus      ibex_ahb_arbiter_if.master (fetch, LSU and AHB signals)
// Parameters:
//   INSTR_HPROT  HPROT for fetches   (opcode, privileged)
//   DATA_HPROT   HPROT for LSU       (data,   privileged)
// Configuration macro:
//   IBEX_AHB_RR_EN  defined   -> round-robin arbitration between requesters
//                   undefined -> fixed priority, LSU above fetch
// ----------------------------------------------------------------------------
module ibex_ahb_arbiter
    import ibex_ahb_pkg::*;
#(
    parameter logic [3:0] INSTR_HPROT = 4'b0010,
    parameter logic [3:0] DATA_HPROT  = 4'b0011
) (
    input logic               HCLK,
    input logic               HRESETn,
    ibex_ahb_arbiter_if.master bus
);

    logic        sel_instr_s;
    logic        sel_data_s;
    logic        instr_gnt_s;
    logic        data_gnt_s;

    logic [2:0]  be_hsize_s;
    logic [1:0]  be_lsb_s;

    logic [31:0] haddr_s;
    logic [1:0]  htrans_s;
    logic [2:0]  hsize_s;
    logic        hwrite_s;
    logic [3:0]  hprot_s;

    owner_e      owner_q;
    owner_e      owner_d;
    logic [31:0] hwdata_q;
    logic [31:0] hwdata_d;

    logic        instr_rvalid_s;
    logic        data_rvalid_s;

    // The LSU supplies a word address; the low bits come from the byte enables.
    logic        unused_data_addr_lsb_s;
    assign unused_data_addr_lsb_s = ^bus.data_addr_i[1:0];

    ibex_ahb_be_decode u_be_decode (
        .be_i       (bus.data_be_i),
        .hsize_o    (be_hsize_s),
        .addr_lsb_o (be_lsb_s)
    );

`ifdef IBEX_AHB_RR_EN
    // Set when fetch should win the next contended cycle.
    logic rr_instr_q;
    logic rr_instr_d;

    // Arbitration: a lone requester wins, contention goes to the one not granted last
    always_comb begin
        sel_instr_s = 1'b0;
        sel_data_s  = 1'b0;
        if (!HRESETn) begin
            sel_instr_s = 1'b0;
            sel_data_s  = 1'b0;
        end else if (bus.instr_req_i && bus.data_req_i) begin
            sel_instr_s = rr_instr_q;
            sel_data_s  = ~rr_instr_q;
        end else begin
            sel_instr_s = bus.instr_req_i;
            sel_data_s  = bus.data_req_i;
        end
    end

    // Pointer next state: flip to the other requester after every grant
    always_comb begin
        rr_instr_d = rr_instr_q;
        if (instr_gnt_s) begin
            rr_instr_d = 1'b0;
        end else if (data_gnt_s) begin
            rr_instr_d = 1'b1;
        end else begin
            rr_instr_d = rr_instr_q;
        end
    end

    // Round-robin pointer register; fetch has the first turn after reset
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rr_instr_q <= 1'b1;
        end else begin
            rr_instr_q <= rr_instr_d;
        end
    end
`else
    // Arbitration: LSU strictly above fetch
    always_comb begin
        sel_instr_s = 1'b0;
        sel_data_s  = 1'b0;
        if (!HRESETn) begin
            sel_instr_s = 1'b0;
            sel_data_s  = 1'b0;
        end else begin
            sel_data_s  = bus.data_req_i;
            sel_instr_s = bus.instr_req_i & ~bus.data_req_i;
        end
    end
`endif

    // Wait states stall the grant, so the address phase stays on the bus
    // unchanged while the requester holds its request.
    assign instr_gnt_s = sel_instr_s & bus.HREADY;
    assign data_gnt_s  = sel_data_s  & bus.HREADY;

    // Address-phase mux driven from the arbitration winner
    always_comb begin
        haddr_s  = 32'h0000_0000;
        htrans_s = HTRANS_IDLE;
        hsize_s  = 3'b000;
        hwrite_s = 1'b0;
        hprot_s  = 4'b0000;
        if (sel_data_s) begin
            haddr_s  = {bus.data_addr_i[31:2], be_lsb_s};
            htrans_s = HTRANS_NONSEQ;
            hsize_s  = be_hsize_s;
            hwrite_s = bus.data_we_i;
            hprot_s  = DATA_HPROT;
        end else if (sel_instr_s) begin
            haddr_s  = bus.instr_addr_i;
            htrans_s = HTRANS_NONSEQ;
            hsize_s  = HSIZE_WORD;
            hwrite_s = 1'b0;
            hprot_s  = INSTR_HPROT;
        end else begin
            haddr_s  = 32'h0000_0000;
            htrans_s = HTRANS_IDLE;
            hsize_s  = 3'b000;
            hwrite_s = 1'b0;
            hprot_s  = 4'b0000;
        end
    end

    // Data-phase next state: advances only when the current data phase completes
    always_comb begin
        owner_d  = owner_q;
        hwdata_d = hwdata_q;
        if (bus.HREADY) begin
            if (instr_gnt_s) begin
                owner_d = OWN_INSTR;
            end else if (data_gnt_s) begin
                owner_d = OWN_DATA;
            end else begin
                owner_d = OWN_NONE;
            end
            if (data_gnt_s && bus.data_we_i) begin
                hwdata_d = bus.data_wdata_i;
            end else begin
                hwdata_d = hwdata_q;
            end
        end else begin
            owner_d  = owner_q;
            hwdata_d = hwdata_q;
        end
    end

    // Data-phase owner and write-data registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner_q  <= OWN_NONE;
            hwdata_q <= 32'h0000_0000;
        end else begin
            owner_q  <= owner_d;
            hwdata_q <= hwdata_d;
        end
    end

    // Responses complete on the HREADY=1 cycle of the owner's data phase; for
    // an ERROR this is the second cycle of the two-cycle response.
    assign instr_rvalid_s = (owner_q == OWN_INSTR) & bus.HREADY;
    assign data_rvalid_s  = (owner_q == OWN_DATA)  & bus.HREADY;

    assign bus.instr_gnt_o    = instr_gnt_s;
    assign bus.data_gnt_o     = data_gnt_s;
    assign bus.instr_rvalid_o = instr_rvalid_s;
    assign bus.data_rvalid_o  = data_rvalid_s;
    assign bus.instr_rdata_o  = bus.HRDATA;
    assign bus.data_rdata_o   = bus.HRDATA;
    assign bus.instr_err_o    = (bus.HRESP == HRESP_ERROR) & instr_rvalid_s;
    assign bus.data_err_o     = (bus.HRESP == HRESP_ERROR) & data_rvalid_s;

    assign bus.HADDR  = haddr_s;
    assign bus.HTRANS = htrans_s;
    assign bus.HSIZE  = hsize_s;
    assign bus.HWRITE = hwrite_s;
    assign bus.HPROT  = hprot_s;
    assign bus.HWDATA = hwdata_q;

endmodule

// File: tb/tb_ibex_ahb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ibex_ahb_arbiter
// Self-checking bench for ibex_ahb_arbiter: reset values, a byte-enable
// decode table, hand-written multi-cycle sequences (fetch, byte write,
// contention, wait states, error response, mid-transfer reset) and a
// randomized run against a transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_ibex_ahb_arbiter;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ibex_ahb_arbiter_if bus();

    ibex_ahb_arbiter #(
        .INSTR_HPROT (4'b0010),
        .DATA_HPROT  (4'b0011)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: responses still owed, in issue order (1 = fetch, 2 = LSU)
    int          pend_q[$];
    int          last_win;
    logic [31:0] m_hwdata;
    logic        e_ig;
    logic        e_dg;

    // Values sampled from the DUT in the most recent cycle
    logic [31:0] s_haddr, s_hwdata, s_irdata, s_drdata;
    logic [2:0]  s_hsize;
    logic [1:0]  s_htrans;
    logic        s_hwrite, s_ig, s_dg, s_irv, s_drv, s_ierr, s_derr;

    typedef struct {
        logic [3:0]  be;
        logic [31:0] addr;
        logic [2:0]  sz;
        logic [31:0] haddr;
    } be_vec_t;
    be_vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte enables to (size, low address), from the rule: one byte -> byte
    // access at that lane, an aligned lane pair -> halfword, else word.
    function automatic void be_map(input logic [3:0] be, output logic [2:0] sz, output logic [1:0] lsb);
        int ones = 0;
        int low  = 0;
        for (int b = 3; b >= 0; b--) begin
            if (be[b]) begin
                ones++;
                low = b;
            end
        end
        sz  = 3'd2;
        lsb = 2'd0;
        if (ones == 1) begin
            sz  = 3'd0;
            lsb = 2'(low);
        end else if (ones == 2 && (low == 0 || low == 2) && be[low + 1]) begin
            sz  = 3'd1;
            lsb = 2'(low);
        end
    endfunction

    task automatic model_reset();
        pend_q.delete();
        last_win = 2;
        m_hwdata = 32'h0;
        e_ig     = 1'b0;
        e_dg     = 1'b0;
    endtask

    task automatic sample();
        s_haddr  = bus.HADDR;   s_hsize  = bus.HSIZE;   s_htrans = bus.HTRANS;
        s_hwrite = bus.HWRITE;  s_hwdata = bus.HWDATA;
        s_ig     = bus.instr_gnt_o;    s_dg   = bus.data_gnt_o;
        s_irv    = bus.instr_rvalid_o; s_drv  = bus.data_rvalid_o;
        s_ierr   = bus.instr_err_o;    s_derr = bus.data_err_o;
        s_irdata = bus.instr_rdata_o;  s_drdata = bus.data_rdata_o;
    endtask

    // One clock cycle: drive, compare everything against the model, advance.
    task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dwe, input logic [3:0] be, input logic [31:0] da,
                         input logic [31:0] wd, input logic [31:0] hr,
                         input logic hrdy, input logic hrsp);
        int          win;
        int          front;
        logic [2:0]  sz;
        logic [1:0]  lsb;
        logic [31:0] e_addr;
        logic [2:0]  e_size;
        logic [3:0]  e_prot;
        bus.instr_req_i = ir;  bus.instr_addr_i = ia;
        bus.data_req_i  = dr;  bus.data_we_i = dwe; bus.data_be_i = be;
        bus.data_addr_i = da;  bus.data_wdata_i = wd;
        bus.HRDATA = hr; bus.HREADY = hrdy; bus.HRESP = hrsp;
        #2;
        sample();
        win = 0;
        if (ir && dr) begin
`ifdef IBEX_AHB_RR_EN
            win = (last_win == 2) ? 1 : 2;
`else
            win = 2;
`endif
        end else if (dr) begin
            win = 2;
        end else if (ir) begin
            win = 1;
        end
        be_map(be, sz, lsb);
        e_addr = (win == 1) ? ia : (win == 2) ? {da[31:2], lsb} : 32'h0;
        e_size = (win == 1) ? 3'd2 : (win == 2) ? sz : 3'd0;
        e_prot = (win == 1) ? 4'b0010 : (win == 2) ? 4'b0011 : 4'b0000;
        front  = (pend_q.size() != 0) ? pend_q[0] : 0;
        e_ig   = (win == 1) && hrdy;
        e_dg   = (win == 2) && hrdy;
        chk("htrans",  32'(bus.HTRANS), (win != 0) ? 32'h2 : 32'h0);
        chk("haddr",   bus.HADDR, e_addr);
        chk("hsize",   32'(bus.HSIZE), 32'(e_size));
        chk("hwrite",  32'(bus.HWRITE), 32'((win == 2) && dwe));
        chk("hprot",   32'(bus.HPROT), 32'(e_prot));
        chk("hwdata",  bus.HWDATA, m_hwdata);
        chk("i_gnt",   32'(bus.instr_gnt_o), 32'(e_ig));
        chk("d_gnt",   32'(bus.data_gnt_o), 32'(e_dg));
        chk("i_rvalid", 32'(bus.instr_rvalid_o), 32'((front == 1) && hrdy));
        chk("d_rvalid", 32'(bus.data_rvalid_o), 32'((front == 2) && hrdy));
        chk("i_err",   32'(bus.instr_err_o), 32'((front == 1) && hrdy && hrsp));
        chk("d_err",   32'(bus.data_err_o), 32'((front == 2) && hrdy && hrsp));
        chk("i_rdata", bus.instr_rdata_o, hr);
        chk("d_rdata", bus.data_rdata_o, hr);
        @(posedge HCLK);
        if (hrdy) begin
            if (pend_q.size() != 0) void'(pend_q.pop_front());
            if (win != 0) begin
                pend_q.push_back(win);
                last_win = win;
                if (win == 2 && dwe) m_hwdata = wd;
            end
        end
        #1;
    endtask

    task automatic idle(input logic [31:0] hr);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, hr, 1'b1, 1'b0);
    endtask

    initial begin
        logic        ir, dr, dwe, hrdy, hrsp;
        logic [3:0]  be;
        logic [31:0] ia, da, wd;
        int          err_st;

        tbl[0]  = '{4'b0001, 32'h1000_0000, 3'b000, 32'h1000_0000};
        tbl[1]  = '{4'b0010, 32'h1000_0004, 3'b000, 32'h1000_0005};
        tbl[2]  = '{4'b0100, 32'h1000_0008, 3'b000, 32'h1000_000A};
        tbl[3]  = '{4'b1000, 32'h1000_000C, 3'b000, 32'h1000_000F};
        tbl[4]  = '{4'b0011, 32'h2000_0010, 3'b001, 32'h2000_0010};
        tbl[5]  = '{4'b1100, 32'h2000_0014, 3'b001, 32'h2000_0016};
        tbl[6]  = '{4'b1111, 32'h3000_0018, 3'b010, 32'h3000_0018};
        tbl[7]  = '{4'b0000, 32'h3000_001C, 3'b010, 32'h3000_001C};
        tbl[8]  = '{4'b0101, 32'h4000_0020, 3'b010, 32'h4000_0020};
        tbl[9]  = '{4'b0110, 32'h4000_0024, 3'b010, 32'h4000_0024};
        tbl[10] = '{4'b1110, 32'hFFFF_FFFC, 3'b010, 32'hFFFF_FFFC};

        // Reset with both requests asserted: address phase must stay idle
        bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h100;
        bus.data_req_i  = 1'b1; bus.data_we_i = 1'b1; bus.data_be_i = 4'hF;
        bus.data_addr_i = 32'h200; bus.data_wdata_i = 32'h1234_5678;
        bus.HRDATA = 32'h0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        model_reset();
        #3;
        sample();
        chk("rst_htrans", 32'(s_htrans), 32'h0);
        chk("rst_haddr",  s_haddr, 32'h0);
        chk("rst_hsize",  32'(s_hsize), 32'h0);
        chk("rst_hwrite", 32'(s_hwrite), 32'h0);
        chk("rst_hprot",  32'(bus.HPROT), 32'h0);
        chk("rst_hwdata", s_hwdata, 32'h0);
        chk("rst_gnt",    32'({s_ig, s_dg}), 32'h0);
        chk("rst_rvalid", 32'({s_irv, s_drv, s_ierr, s_derr}), 32'h0);
        @(posedge HCLK); @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // Single fetch, zero wait states
        cycle(1'b1, 32'h0000_0100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("fetch_gnt", 32'(s_ig), 32'h1);
        chk("fetch_htrans", 32'(s_htrans), 32'h2);
        chk("fetch_hsize", 32'(s_hsize), 32'h2);
        idle(32'h0000_0013);
        chk("fetch_rvalid", 32'(s_irv), 32'h1);
        chk("fetch_rdata", s_irdata, 32'h0000_0013);

        // Byte write
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'b0100, 32'h2000_0000, 32'h00AB_0000, 32'h0, 1'b1, 1'b0);
        chk("bw_haddr", s_haddr, 32'h2000_0002);
        chk("bw_hsize", 32'(s_hsize), 32'h0);
        chk("bw_hwrite", 32'(s_hwrite), 32'h1);
        idle(32'h0);
        chk("bw_hwdata", s_hwdata, 32'h00AB_0000);
        chk("bw_rvalid", 32'(s_drv), 32'h1);

        // Byte-enable decode table
        for (int i = 0; i < 11; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0, tbl[i].be, tbl[i].addr, 32'h0, 32'(i), 1'b1, 1'b0);
            chk("tbl_hsize", 32'(s_hsize), 32'(tbl[i].sz));
            chk("tbl_haddr", s_haddr, tbl[i].haddr);
        end
        idle(32'h0);

        // Simultaneous requests
        cycle(1'b1, 32'h300, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("sim1_dgnt", 32'(s_dg), 32'h1);
        chk("sim1_ignt", 32'(s_ig), 32'h0);
        cycle(1'b1, 32'h300, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 32'hD00D, 1'b1, 1'b0);
        chk("sim2_ignt", 32'(s_ig), 32'h1);
        chk("sim2_drvalid", 32'(s_drv), 32'h1);
        idle(32'hF00D);
        chk("sim3_irvalid", 32'(s_irv), 32'h1);

        // Wait states during an LSU read, then back-to-back fetches
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h500, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int w = 0; w < 2; w++) begin
            cycle(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
            chk("ws_no_gnt", 32'({s_ig, s_dg}), 32'h0);
            chk("ws_no_rvalid", 32'({s_irv, s_drv}), 32'h0);
            chk("ws_haddr", s_haddr, 32'h100);
        end
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hCAFE, 1'b1, 1'b0);
        chk("ws_drvalid", 32'(s_drv), 32'h1);
        chk("ws_ignt_100", 32'(s_ig), 32'h1);
        cycle(1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h1, 1'b1, 1'b0);
        chk("ws_ignt_104", 32'(s_ig), 32'h1);
        chk("ws_haddr_104", s_haddr, 32'h104);
        chk("ws_irvalid_100", 32'(s_irv), 32'h1);
        idle(32'h2);
        chk("ws_irvalid_104", 32'(s_irv), 32'h1);

        // Two-cycle ERROR response on an LSU read
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("err1_no_gnt", 32'({s_ig, s_dg}), 32'h0);
        chk("err1_no_rvalid", 32'(s_drv), 32'h0);
        cycle(1'b1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        chk("err2_drvalid", 32'(s_drv), 32'h1);
        chk("err2_derr", 32'(s_derr), 32'h1);
        idle(32'h0);
        chk("err3_ierr", 32'(s_ierr), 32'h0);

        // Reset asserted in the middle of an LSU data phase
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h700, 32'h0, 32'h0, 1'b1, 1'b0);
        bus.instr_req_i = 1'b1; bus.data_req_i = 1'b1; bus.HREADY = 1'b1;
        HRESETn = 1'b0;
        #2;
        sample();
        chk("mrst_htrans", 32'(s_htrans), 32'h0);
        chk("mrst_drvalid", 32'(s_drv), 32'h0);
        chk("mrst_gnt", 32'({s_ig, s_dg}), 32'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        model_reset();
        idle(32'h0);
        chk("mrst_no_rvalid", 32'({s_irv, s_drv}), 32'h0);

        // Randomized traffic; requests stay stable until granted
        ir = 1'b0; dr = 1'b0; dwe = 1'b0; be = 4'h0;
        ia = 32'h0; da = 32'h0; wd = 32'h0; err_st = 0;
        for (int k = 0; k < 1500; k++) begin
            if (!(ir && !e_ig)) begin
                ir = ($urandom_range(0, 2) != 0);
                ia = $urandom() & 32'hFFFF_FFFC;
            end
            if (!(dr && !e_dg)) begin
                dr  = ($urandom_range(0, 2) != 0);
                dwe = ($urandom_range(0, 1) != 0);
                be  = 4'($urandom_range(0, 15));
                da  = $urandom();
                wd  = $urandom();
            end
            if (err_st == 1) begin
                hrdy = 1'b1; hrsp = 1'b1; err_st = 0;
            end else if (pend_q.size() != 0 && $urandom_range(0, 7) == 0) begin
                hrdy = 1'b0; hrsp = 1'b1; err_st = 1;
            end else begin
                hrdy = ($urandom_range(0, 3) != 0); hrsp = 1'b0;
            end
            cycle(ir, ia, dr, dwe, be, da, wd, $urandom(), hrdy, hrsp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
